unary_hdc_bundler: RTL



---
 rtl/unary_hdc_pkg.sv | 25 ++
 rtl/unary_gt_cmp.sv | 21 ++
 rtl/unary_hdc_bundler.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/unary_hdc_pkg.sv
// -----------------------------------------------------------------------------
// unary_hdc_pkg
// Shared types and constants for the unary hyperdimensional bundler.
//   state_e       : bundler FSM states (ACCUM collects features, DONE presents
//                   the bundled hypervector).
//   cnt_width()   : counter width needed to hold 0..max_feat.
//   DEF_*         : default parameter values for the bundler.
// Optional feature macro used by the bundler: UNARY_HDC_RAW_CNT_EN.
// -----------------------------------------------------------------------------
package unary_hdc_pkg;

  localparam int DEF_STREAM_LEN = 16;
  localparam int DEF_D          = 64;
  localparam int DEF_MAX_FEAT   = 255;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_e;

  function automatic int cnt_width(input int max_feat);
    return $clog2(max_feat + 1);
  endfunction

endpackage

// File: rtl/unary_gt_cmp.sv
// -----------------------------------------------------------------------------
// unary_gt_cmp
// Combinational "feature > level" test on two unary words. For thermometer
// codes, a feature exceeds a level exactly when it has a one where the level
// has a zero. Non-thermometer words are evaluated with the same expression.
// Ports:
//   i_feat [STREAM_LEN] : feature word
//   i_lvl  [STREAM_LEN] : level word
//   o_gt                : |(i_feat & ~i_lvl)
// -----------------------------------------------------------------------------
module unary_gt_cmp #(
  parameter int STREAM_LEN = 16
) (
  input  logic [STREAM_LEN-1:0] i_feat,
  input  logic [STREAM_LEN-1:0] i_lvl,
  output logic                  o_gt
);

  assign o_gt = |(i_feat & ~i_lvl);

endmodule

// File: rtl/unary_hdc_bundler.sv
// -----------------------------------------------------------------------------
// unary_hdc_bundler
// Streams thermometer-coded features, encodes each against D level streams
// (hv[d] = feature > level[d]), accumulates per-dimension counts over a sample
// and emits a majority-thresholded hypervector (2*cnt > n, ties give 0).
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. The producer holds data stable while valid=1 and ready=0;
// ready may depend on state only, never on valid.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   lvl_unary [D][SL] : per-dimension level streams, stable during a sample
//   feat_valid/ready  : feature handshake; feat_unary data, feat_last ends sample
//   out_valid/ready   : result handshake
//   bundle_hv [D]     : majority-bundled hypervector (bit d = dimension d)
//   overflow          : sample held more than MAX_FEAT features
//   bundle_cnt [D][CW]: saturated counts      (only with UNARY_HDC_RAW_CNT_EN)
//   bundle_n  [CW]    : saturated feature cnt (only with UNARY_HDC_RAW_CNT_EN)
// Debug: the FSM state is the r_state register (type state_e).
// -----------------------------------------------------------------------------
module unary_hdc_bundler
  import unary_hdc_pkg::*;
#(
  parameter int STREAM_LEN = DEF_STREAM_LEN,
  parameter int D          = DEF_D,
  parameter int MAX_FEAT   = DEF_MAX_FEAT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [D-1:0][STREAM_LEN-1:0]   lvl_unary,
  input  logic                           feat_valid,
  output logic                           feat_ready,
  input  logic [STREAM_LEN-1:0]          feat_unary,
  input  logic                           feat_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [D-1:0]                   bundle_hv,
  output logic                           overflow
`ifdef UNARY_HDC_RAW_CNT_EN
  ,
  output logic [D-1:0][cnt_width(MAX_FEAT)-1:0] bundle_cnt,
  output logic [cnt_width(MAX_FEAT)-1:0]        bundle_n
`endif
);

  localparam int               CNT_W = cnt_width(MAX_FEAT);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_FEAT);

  state_e           r_state;
  state_e           w_state_next;
  logic             w_feat_ready;
  logic             w_out_valid;
  logic             w_accept;
  logic             w_out_fire;

  logic [D-1:0]     w_hv;
  logic [D-1:0]     w_hv_thr;
  logic [CNT_W-1:0] r_cnt      [D];
  logic [CNT_W-1:0] w_cnt_next [D];
  logic [CNT_W-1:0] r_n;
  logic [CNT_W-1:0] w_n_next;
  logic             r_ovf;
  logic             w_ovf_next;
  logic [D-1:0]     r_bundle_hv;
  logic             r_overflow;

  // Per-dimension encoders
  for (genvar g = 0; g < D; g++) begin : g_cmp
    unary_gt_cmp #(.STREAM_LEN(STREAM_LEN)) u_cmp (
      .i_feat (feat_unary),
      .i_lvl  (lvl_unary[g]),
      .o_gt   (w_hv[g])
    );
  end

  // Saturating next counts, sticky overflow and majority threshold. The
  // threshold is evaluated on the post-accept counts so the last feature of a
  // sample is included. One extra bit keeps 2*cnt from wrapping.
  always_comb begin
    w_n_next   = (r_n == MAX_C) ? r_n : r_n + CNT_W'(1);
    w_ovf_next = r_ovf | (r_n == MAX_C);
    w_hv_thr   = '0;
    for (int d = 0; d < D; d++) begin
      w_cnt_next[d] = (w_hv[d] && (r_cnt[d] != MAX_C)) ? r_cnt[d] + CNT_W'(1)
                                                        : r_cnt[d];
      w_hv_thr[d]   = ({w_cnt_next[d], 1'b0} > {1'b0, w_n_next});
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state and handshake outputs
  always_comb begin
    w_state_next = r_state;
    w_feat_ready = 1'b0;
    w_out_valid  = 1'b0;
    case (r_state)
      ACCUM: begin
        w_feat_ready = 1'b1;
        if (feat_valid && feat_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = ACCUM;
        end
      end
      default: w_state_next = ACCUM;
    endcase
  end

  assign w_accept   = feat_valid & w_feat_ready;
  assign w_out_fire = w_out_valid & out_ready;

  // Accumulators and result registers. Counters freeze in DONE (no accepts)
  // and are cleared when the result is taken. bundle_hv keeps its last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int d = 0; d < D; d++) begin
        r_cnt[d] <= '0;
      end
      r_n         <= '0;
      r_ovf       <= 1'b0;
      r_bundle_hv <= '0;
      r_overflow  <= 1'b0;
    end else if (w_accept) begin
      for (int d = 0; d < D; d++) begin
        r_cnt[d] <= w_cnt_next[d];
      end
      r_n   <= w_n_next;
      r_ovf <= w_ovf_next;
      if (feat_last) begin
        r_bundle_hv <= w_hv_thr;
        r_overflow  <= w_ovf_next;
      end
    end else if (w_out_fire) begin
      for (int d = 0; d < D; d++) begin
        r_cnt[d] <= '0;
      end
      r_n   <= '0;
      r_ovf <= 1'b0;
    end
  end

`ifdef UNARY_HDC_RAW_CNT_EN
  // Raw counts captured together with bundle_hv for soft bundling / debug.
  logic [D-1:0][CNT_W-1:0] r_bundle_cnt;
  logic [CNT_W-1:0]        r_bundle_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bundle_cnt <= '0;
      r_bundle_n   <= '0;
    end else if (w_accept && feat_last) begin
      for (int d = 0; d < D; d++) begin
        r_bundle_cnt[d] <= w_cnt_next[d];
      end
      r_bundle_n <= w_n_next;
    end
  end

  assign bundle_cnt = r_bundle_cnt;
  assign bundle_n   = r_bundle_n;
`else
  // Raw counts are not exported in this build.
`endif

  assign feat_ready = w_feat_ready;
  assign out_valid  = w_out_valid;
  assign bundle_hv  = r_bundle_hv;
  assign overflow   = r_overflow;

endmodule
